hsv_mode_ctrl: RTL and testbench

//  Parametrised HSV colour-setpoint generator for the RGB LED path. Takes a mode code and

---
 rtl/hsv_pkg.sv | 18 +
 rtl/hsv_tick_div.sv | 33 +++
 rtl/hsv_mode_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hsv_mode_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared constants for the HSV setpoint generator: mode encodings and default ranges.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hsv_pkg;

    // Mode encodings on the mode input
    localparam int MODE_STATIC  = 0;
    localparam int MODE_JUMP    = 1;
    localparam int MODE_SWEEP   = 2;
    localparam int MODE_HUE_ADJ = 3;
    localparam int MODE_VAL_ADJ = 4;
    localparam int MODE_SAT_ADJ = 5;

    // Default colour-space ranges
    localparam int HUE_MOD_DEF  = 360;
    localparam int SV_MAX_DEF   = 100;

endpackage

// File: rtl/hsv_tick_div.sv
// Programmable tick divider: counts 0..term and pulses tick on the terminal count.
// Latency: tick is combinational from the current count; count advances each enabled cycle.
// Backpressure: none; clr overrides en and suppresses tick in the same cycle.
//
// Ports: clk, reset_n (async active-low), clr (sync clear), en (count enable),
//        term (terminal count, i.e. period-1), tick (one-cycle pulse at terminal count).
module hsv_tick_div #(
    parameter  int DIV = 2,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic          tick
);

    logic [CW-1:0] cnt;

    assign tick = en & ~clr & (cnt == term);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == term) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hsv_mode_ctrl.sv
// HSV colour-setpoint generator: mode-driven hue/sat/val stepping with wrap/clamp and hold-to-accelerate.
// Latency: 1 cycle from divider tick to new setpoint; upd pulses in the same cycle the new value appears.
// Backpressure: none; free-running, consumer samples hue/sat/val whenever upd is high.
//
// Ports: clk, reset_n (async active-low), mode (operating mode), adj_btn (adjust hold),
//        dir_sw (0 inc / 1 dec), hue/sat/val (registered setpoints), upd (change strobe).
module hsv_mode_ctrl
    import hsv_pkg::*;
#(
    parameter int HW          = 9,
    parameter int SVW         = 7,
    parameter int MODE_W      = 4,
    parameter int HUE_MOD     = HUE_MOD_DEF,
    parameter int SV_MAX      = SV_MAX_DEF,
    parameter int HUE_INIT    = 120,
    parameter int SV_INIT     = 80,
    parameter int AUTO_STEP   = 60,
    parameter int DIV_SLOW    = 10_000_000,
    parameter int DIV_FAST    = 500_000,
    parameter int DIV_ADJ     = 1_000_000,
    parameter int ACCEL_AFTER = 16,
    parameter int ACCEL_STEP  = 5,
    parameter int SV_WRAP     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              adj_btn,
    input  logic              dir_sw,
    output logic [HW-1:0]     hue,
    output logic [SVW-1:0]    sat,
    output logic [SVW-1:0]    val,
    output logic              upd
);

    // One shared divider sized for the longest period
    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST)
                           ? ((DIV_SLOW > DIV_ADJ) ? DIV_SLOW : DIV_ADJ)
                           : ((DIV_FAST > DIV_ADJ) ? DIV_FAST : DIV_ADJ);
    localparam int CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int AW = $clog2(ACCEL_AFTER + 1);

    localparam logic [HW-1:0]         HUE_INIT_V = HW'(HUE_INIT);
    localparam logic [HW-1:0]         AUTO_V     = HW'(AUTO_STEP);
    localparam logic [HW-1:0]         HSTEP_1    = HW'(1);
    localparam logic [HW-1:0]         HSTEP_A    = HW'(ACCEL_STEP);
    localparam logic [SVW-1:0]        SV_INIT_V  = SVW'(SV_INIT);
    localparam logic [SVW-1:0]        SSTEP_1    = SVW'(1);
    localparam logic [SVW-1:0]        SSTEP_A    = SVW'(ACCEL_STEP);
    localparam logic [AW-1:0]         ACC_MAX    = AW'(ACCEL_AFTER);
    localparam logic signed [HW+1:0]  HMOD       = (HW+2)'(HUE_MOD);
    localparam logic signed [SVW+1:0] SMAX       = (SVW+2)'(SV_MAX);
    localparam logic signed [SVW+1:0] SRANGE     = (SVW+2)'(SV_MAX + 1);

    // Hue step with true modulo wrap in both directions (step assumed < HUE_MOD)
    function automatic logic [HW-1:0] hue_step(input logic [HW-1:0] h,
                                               input logic [HW-1:0] st,
                                               input logic          dec);
        logic signed [HW+1:0] t;
        if (dec) t = $signed({2'b00, h}) - $signed({2'b00, st});
        else     t = $signed({2'b00, h}) + $signed({2'b00, st});
        if (t[HW+1])       t = t + HMOD;
        else if (t >= HMOD) t = t - HMOD;
        return t[HW-1:0];
    endfunction

    // S/V step: wrap across 0..SV_MAX or clamp at the ends
    function automatic logic [SVW-1:0] sv_step(input logic [SVW-1:0] x,
                                               input logic [SVW-1:0] st,
                                               input logic           dec);
        logic signed [SVW+1:0] t;
        if (dec) t = $signed({2'b00, x}) - $signed({2'b00, st});
        else     t = $signed({2'b00, x}) + $signed({2'b00, st});
        if (SV_WRAP != 0) begin
            if (t[SVW+1])     t = t + SRANGE;
            else if (t > SMAX) t = t - SRANGE;
        end else begin
            if (t[SVW+1])     t = '0;
            else if (t > SMAX) t = SMAX;
        end
        return t[SVW-1:0];
    endfunction

    logic [MODE_W-1:0] mode_q;
    logic [AW-1:0]     acc;
    logic              is_static, is_jump, is_sweep, is_hadj, is_vadj, is_sadj, is_adj;
    logic              div_run, div_clr, tick, acc_sat, chg;
    logic [CW-1:0]     term;
    logic [HW-1:0]     hstep, hue_d;
    logic [SVW-1:0]    sstep, sat_d, val_d;

    assign is_static = (mode == MODE_W'(MODE_STATIC));
    assign is_jump   = (mode == MODE_W'(MODE_JUMP));
    assign is_sweep  = (mode == MODE_W'(MODE_SWEEP));
    assign is_hadj   = (mode == MODE_W'(MODE_HUE_ADJ));
    assign is_vadj   = (mode == MODE_W'(MODE_VAL_ADJ));
    assign is_sadj   = (mode == MODE_W'(MODE_SAT_ADJ));
    assign is_adj    = is_hadj | is_vadj | is_sadj;

    // Releasing the button or changing mode restarts the period from zero
    assign div_run = is_jump | is_sweep | (is_adj & adj_btn);
    assign div_clr = (mode != mode_q) | ~div_run;

    // Terminal count follows the registered mode; it only matters once mode == mode_q
    always_comb begin
        term = '0;
        if (mode_q == MODE_W'(MODE_JUMP))
            term = CW'(DIV_SLOW - 1);
        else if (mode_q == MODE_W'(MODE_SWEEP) || mode_q == MODE_W'(MODE_HUE_ADJ))
            term = CW'(DIV_FAST - 1);
        else if (mode_q == MODE_W'(MODE_VAL_ADJ) || mode_q == MODE_W'(MODE_SAT_ADJ))
            term = CW'(DIV_ADJ - 1);
    end

    hsv_tick_div #(.DIV(DIV_MAX)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (div_clr),
        .en      (div_run),
        .term    (term),
        .tick    (tick)
    );

    assign acc_sat = (acc == ACC_MAX);
    assign hstep   = acc_sat ? HSTEP_A : HSTEP_1;
    assign sstep   = acc_sat ? SSTEP_A : SSTEP_1;

    always_comb begin
        hue_d = hue;
        sat_d = sat;
        val_d = val;
        if (is_static)
            hue_d = HUE_INIT_V;
        else if (tick) begin
            if (is_jump)       hue_d = hue_step(hue, AUTO_V, 1'b0);
            else if (is_sweep) hue_d = hue_step(hue, HSTEP_1, 1'b0);
            else if (is_hadj)  hue_d = hue_step(hue, hstep, dir_sw);
            else if (is_vadj)  val_d = sv_step(val, sstep, dir_sw);
            else if (is_sadj)  sat_d = sv_step(sat, sstep, dir_sw);
        end
    end

    // A clamped step that leaves the value unchanged produces no strobe
    assign chg = (hue_d != hue) | (sat_d != sat) | (val_d != val);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hue    <= HUE_INIT_V;
            sat    <= SV_INIT_V;
            val    <= SV_INIT_V;
            upd    <= 1'b0;
            mode_q <= '0;
            acc    <= '0;
        end else begin
            hue    <= hue_d;
            sat    <= sat_d;
            val    <= val_d;
            upd    <= chg;
            mode_q <= mode;
            if (div_clr || !is_adj)
                acc <= '0;
            else if (tick && !acc_sat)
                acc <= acc + AW'(1);
        end
    end

endmodule

// File: tb/tb_hsv_mode_ctrl.sv
// Directed bench for hsv_mode_ctrl with short divider periods; wrap and clamp variants side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_hsv_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] mode;
    logic       adj_btn;
    logic       dir_sw;
    logic [8:0] hue, hue_c;
    logic [6:0] sat, sat_c, val, val_c;
    logic       upd, upd_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hsv_mode_ctrl #(
        .DIV_SLOW(8), .DIV_FAST(2), .DIV_ADJ(4), .ACCEL_AFTER(3), .SV_WRAP(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .adj_btn(adj_btn), .dir_sw(dir_sw),
        .hue(hue), .sat(sat), .val(val), .upd(upd)
    );

    hsv_mode_ctrl #(
        .DIV_SLOW(8), .DIV_FAST(2), .DIV_ADJ(4), .ACCEL_AFTER(3), .SV_WRAP(0)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .mode(mode), .adj_btn(adj_btn), .dir_sw(dir_sw),
        .hue(hue_c), .sat(sat_c), .val(val_c), .upd(upd_c)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance n cycles, counting upd pulses of the wrap and clamp instances
    task automatic cyc_upd(input int n, output int cu, output int cc);
        cu = 0;
        cc = 0;
        repeat (n) begin
            @(negedge clk);
            if (upd)   cu++;
            if (upd_c) cc++;
        end
    endtask

    initial begin
        int k, cu, cc, nchg;
        reset_n = 1'b0;
        mode    = 4'd0;
        adj_btn = 1'b0;
        dir_sw  = 1'b0;
        cyc(3);
        chk("rst_hue", int'(hue), 120);
        chk("rst_sat", int'(sat), 80);
        chk("rst_val", int'(val), 80);
        chk("rst_upd", int'(upd), 0);
        reset_n = 1'b1;
        cyc(1);
        chk("post_rst_upd", int'(upd), 0);

        // Sweep from 120 to 200, then async reset mid-cycle
        mode = 4'd2;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (hue != 9'd200 && k < 400);
        chk("sweep_cycles", k, 161);
        chk("sweep_hue", int'(hue), 200);
        chk("sweep_upd", int'(upd), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_hue", int'(hue), 120);
        chk("arst_sat", int'(sat), 80);
        chk("arst_val", int'(val), 80);
        chk("arst_upd", int'(upd), 0);
        @(negedge clk);
        mode = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1);

        // Jump: 120 -> 180 -> 240 -> 300 -> 0 -> 60
        mode = 4'd1;
        cyc(25);
        chk("jump_300", int'(hue), 300);
        cyc_upd(8, cu, cc);
        chk("jump_wrap0", int'(hue), 0);
        chk("jump_wrap0_upd", cu, 1);
        cyc_upd(8, cu, cc);
        chk("jump_60", int'(hue), 60);
        chk("jump_60_upd", cu, 1);

        // Sweep 60 -> 1 through the 359 -> 0 wrap
        mode = 4'd2;
        cyc_upd(603, cu, cc);
        chk("sweep_hue1", int'(hue), 1);
        chk("sweep_upd_cnt", cu, 301);

        // Hue adjust decrement with acceleration
        mode    = 4'd3;
        dir_sw  = 1'b1;
        adj_btn = 1'b1;
        cyc(3);
        chk("hadj_0", int'(hue), 0);
        cyc(2);
        chk("hadj_359", int'(hue), 359);
        cyc(2);
        chk("hadj_358", int'(hue), 358);
        cyc(2);
        chk("hadj_accel_353", int'(hue), 353);
        adj_btn = 1'b0;
        cyc(2);
        chk("hadj_release", int'(hue), 353);
        adj_btn = 1'b1;
        cyc(2);
        chk("hadj_repress_352", int'(hue), 352);

        // Value adjust: reach 99, then wrap vs clamp
        adj_btn = 1'b0;
        mode    = 4'd4;
        dir_sw  = 1'b0;
        cyc(2);
        chk("vadj_start", int'(val), 80);
        adj_btn = 1'b1;
        cyc(24);
        chk("vadj_98", int'(val), 98);
        chk("vadj_98_c", int'(val_c), 98);
        chk("vadj_sat_hold", int'(sat), 80);
        adj_btn = 1'b0;
        cyc(2);
        adj_btn = 1'b1;
        cyc(4);
        chk("vadj_99", int'(val), 99);
        adj_btn = 1'b0;
        cyc(2);
        adj_btn = 1'b1;
        cyc(4);
        chk("vadj_100", int'(val), 100);
        chk("vadj_100_c", int'(val_c), 100);
        chk("vadj_100_upd", int'(upd), 1);
        chk("vadj_100_upd_c", int'(upd_c), 1);
        cyc_upd(4, cu, cc);
        chk("vadj_wrap0", int'(val), 0);
        chk("vadj_wrap_upd", cu, 1);
        chk("vadj_clamp100", int'(val_c), 100);
        chk("vadj_clamp_upd", cc, 0);

        // Sweep then switch to sat adjust on the would-tick cycle
        mode = 4'd2;
        cyc(4);
        chk("sw_hue353", int'(hue), 353);
        mode = 4'd5;
        cyc(1);
        chk("sw_nostep_hue", int'(hue), 353);
        chk("sw_nostep_upd", int'(upd), 0);
        chk("sw_nostep_sat", int'(sat), 80);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sat == 7'd80 && k < 10);
        chk("sw_sat_delay", k, 4);
        chk("sw_sat81", int'(sat), 81);

        // Undefined mode: everything holds while inputs toggle
        mode = 4'd7;
        cyc(1);
        cu   = 0;
        nchg = 0;
        for (int i = 0; i < 50; i++) begin
            adj_btn = 1'($urandom);
            dir_sw  = 1'($urandom);
            @(negedge clk);
            if (upd || upd_c) cu++;
            if (hue != 9'd353 || sat != 7'd81 || val != 7'd0 ||
                hue_c != 9'd353 || sat_c != 7'd81 || val_c != 7'd100) nchg++;
        end
        chk("m7_upd", cu, 0);
        chk("m7_changes", nchg, 0);
        chk("m7_hue", int'(hue), 353);

        // Static forces hue back to its initial value
        mode = 4'd0;
        cyc(1);
        chk("static_hue", int'(hue), 120);
        chk("static_upd", int'(upd), 1);
        cyc(1);
        chk("static_upd_once", int'(upd), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
